// File: rtl/reg_access_arbiter.sv
// Arbitrates core and debug nibble/pair requests onto one
// single-port register file, returning results on valid/ready.
module reg_access_arbiter #(
  parameter int RR_EN  = 1,
  parameter int NIB_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req_valid,
  output logic                c_req_ready,
  input  logic [1:0]          c_req_op,
  input  logic [ADDR_W-1:0]   c_req_addr,
  input  logic [2*NIB_W-1:0]  c_req_wdata,
  output logic                c_rsp_valid,
  input  logic                c_rsp_ready,
  output logic [2*NIB_W-1:0]  c_rsp_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [1:0]          d_req_op,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [2*NIB_W-1:0]  d_req_wdata,
  output logic                d_rsp_valid,
  input  logic                d_rsp_ready,
  output logic [2*NIB_W-1:0]  d_rsp_rdata,
  output logic                reg_we,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic [NIB_W-1:0]    reg_din,
  input  logic [NIB_W-1:0]    reg_dout,
  output logic                busy
);

  localparam int DW = 2 * NIB_W;

  typedef enum logic [1:0] {
    IDLE, ACC0, ACC1, DONE
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic                last_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DW-1:0]       wdata_q;
  logic [DW-1:0]       rdata_q;
  logic                we_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic [NIB_W-1:0]    din_q;
  logic                rsp_v_q;

  logic                gnt_c;
  logic                gnt_d;
  logic                idle;
  logic                accept;
  logic                rsp_hs;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DW-1:0]       sel_wd;

  // last_q=1 means debug was granted last, so core wins a tie
  assign gnt_c = c_req_valid &&
                 (!d_req_valid || RR_EN == 0 || last_q);
  assign gnt_d = d_req_valid && !gnt_c;

  assign idle        = (state_q == IDLE) && !rst;
  assign c_req_ready = idle && gnt_c;
  assign d_req_ready = idle && gnt_d;
  assign accept      = c_req_ready || d_req_ready;

  assign sel_op   = gnt_d ? d_req_op    : c_req_op;
  assign sel_addr = gnt_d ? d_req_addr  : c_req_addr;
  assign sel_wd   = gnt_d ? d_req_wdata : c_req_wdata;

  assign rsp_hs = rsp_v_q &&
                  (owner_q ? d_rsp_ready : c_rsp_ready);

  assign c_rsp_valid = rsp_v_q && !owner_q;
  assign d_rsp_valid = rsp_v_q && owner_q;
  assign c_rsp_rdata = rdata_q;
  assign d_rsp_rdata = rdata_q;

  // reset must suppress a write already scheduled for this edge
  assign reg_we   = we_q && !rst;
  assign reg_addr = raddr_q;
  assign reg_din  = din_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      din_q   <= '0;
      rsp_v_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ACC0;
            owner_q <= gnt_d;
            last_q  <= gnt_d;
            op_q    <= sel_op;
            addr_q  <= sel_addr;
            wdata_q <= sel_wd;
            rdata_q <= '0;
            we_q    <= sel_op[0];
            raddr_q <= sel_op[1] ?
                       {sel_addr[ADDR_W-1:1], 1'b0} :
                       sel_addr;
            din_q   <= sel_op[1] ?
                       sel_wd[DW-1:NIB_W] :
                       sel_wd[NIB_W-1:0];
          end
        end
        ACC0: begin
          if (!op_q[0]) begin
            if (op_q[1]) rdata_q[DW-1:NIB_W] <= reg_dout;
            else         rdata_q[NIB_W-1:0]  <= reg_dout;
          end
          if (op_q[1]) begin
            state_q <= ACC1;
            we_q    <= op_q[0];
            raddr_q <= {addr_q[ADDR_W-1:1], 1'b1};
            din_q   <= wdata_q[NIB_W-1:0];
          end else begin
            state_q <= DONE;
            we_q    <= 1'b0;
            rsp_v_q <= 1'b1;
          end
        end
        ACC1: begin
          if (!op_q[0]) rdata_q[NIB_W-1:0] <= reg_dout;
          state_q <= DONE;
          we_q    <= 1'b0;
          rsp_v_q <= 1'b1;
        end
        DONE: begin
          if (rsp_hs) begin
            state_q <= IDLE;
            rsp_v_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: scoreboard of
// expected responses, plus a fixed-priority instance.
module tb_reg_access_arbiter;

  localparam logic [1:0] RD4 = 2'b00;
  localparam logic [1:0] WR4 = 2'b01;
  localparam logic [1:0] RD8 = 2'b10;
  localparam logic [1:0] WR8 = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       c_req_valid = 0, d_req_valid = 0;
  logic       c_req_ready, d_req_ready;
  logic [1:0] c_req_op = 0, d_req_op = 0;
  logic [3:0] c_req_addr = 0, d_req_addr = 0;
  logic [7:0] c_req_wdata = 0, d_req_wdata = 0;
  logic       c_rsp_valid, d_rsp_valid;
  logic       c_rsp_ready = 1, d_rsp_ready = 1;
  logic [7:0] c_rsp_rdata, d_rsp_rdata;
  logic       reg_we, busy;
  logic [3:0] reg_addr, reg_din, reg_dout;
  logic [3:0] rf [16];

  logic       c2_req_valid = 0, d2_req_valid = 0;
  logic       c2_req_ready, d2_req_ready;
  logic       c2_rsp_valid, d2_rsp_valid;
  logic [7:0] c2_rsp_rdata, d2_rsp_rdata;
  logic       reg2_we, busy2;
  logic [3:0] reg2_addr, reg2_din, reg2_dout;
  logic [3:0] rf2 [16];

  reg_access_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_req_op(c_req_op), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready),
    .c_rsp_rdata(c_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_op(d_req_op), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .d_rsp_rdata(d_rsp_rdata),
    .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_din(reg_din), .reg_dout(reg_dout),
    .busy(busy)
  );

  reg_access_arbiter #(.RR_EN(0)) dut2 (
    .clk(clk), .rst(rst),
    .c_req_valid(c2_req_valid), .c_req_ready(c2_req_ready),
    .c_req_op(RD4), .c_req_addr(4'h0),
    .c_req_wdata(8'h00),
    .c_rsp_valid(c2_rsp_valid), .c_rsp_ready(1'b1),
    .c_rsp_rdata(c2_rsp_rdata),
    .d_req_valid(d2_req_valid), .d_req_ready(d2_req_ready),
    .d_req_op(RD4), .d_req_addr(4'h1),
    .d_req_wdata(8'h00),
    .d_rsp_valid(d2_rsp_valid), .d_rsp_ready(1'b1),
    .d_rsp_rdata(d2_rsp_rdata),
    .reg_we(reg2_we), .reg_addr(reg2_addr),
    .reg_din(reg2_din), .reg_dout(reg2_dout),
    .busy(busy2)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i]  = 4'h0;
      rf2[i] = 4'h0;
    end
  end

  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_din;
  always @(posedge clk) if (reg2_we) rf2[reg2_addr] <= reg2_din;
  assign reg_dout  = rf[reg_addr];
  assign reg2_dout = rf2[reg2_addr];

  logic [8:0] sb [$];

  logic       tr_we   [0:20];
  logic [3:0] tr_addr [0:20];
  logic [3:0] tr_din  [0:20];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one pop per response handshake
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && ((c_rsp_valid && c_rsp_ready) ||
                 (d_rsp_valid && d_rsp_ready))) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: response with empty queue");
      end else begin
        e = sb.pop_front();
        chk("sb_owner", {31'd0, d_rsp_valid}, {31'd0, e[8]});
        chk("sb_rdata",
            {24'd0, d_rsp_valid ? d_rsp_rdata : c_rsp_rdata},
            {24'd0, e[7:0]});
      end
    end
  end

  task automatic issue(input bit own, input logic [1:0] op,
                       input logic [3:0] addr,
                       input logic [7:0] wd,
                       input logic [7:0] exp, input int exp_lat);
    logic rdy;
    logic vld;
    int n;
    int lat;
    if (own) begin
      d_req_valid = 1; d_req_op = op;
      d_req_addr = addr; d_req_wdata = wd;
    end else begin
      c_req_valid = 1; c_req_op = op;
      c_req_addr = addr; c_req_wdata = wd;
    end
    n = 0;
    do begin
      @(negedge clk);
      rdy = own ? d_req_ready : c_req_ready;
      n++;
    end while (!rdy && n < 50);
    chk("accept", {31'd0, rdy}, 32'd1);
    sb.push_back({own, exp});
    @(posedge clk);
    #1;
    if (own) d_req_valid = 0;
    else     c_req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      tr_we[lat]   = reg_we;
      tr_addr[lat] = reg_addr;
      tr_din[lat]  = reg_din;
      vld = own ? d_rsp_valid : c_rsp_valid;
    end while (!vld && lat < 20);
    chk("latency", lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int cg;
    int n;
    bit ord [0:3];

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_we", {31'd0, reg_we}, 0);
    chk("rst_addr", {28'd0, reg_addr}, 0);
    chk("rst_din", {28'd0, reg_din}, 0);
    chk("rst_crsp", {31'd0, c_rsp_valid}, 0);
    chk("rst_drsp", {31'd0, d_rsp_valid}, 0);
    chk("rst_rdata", {24'd0, c_rsp_rdata}, 0);
    @(posedge clk);
    #1 rst = 0;

    // test 1: core WR8 at odd address hits pair 4/5
    issue(0, WR8, 4'h5, 8'hA3, 8'h00, 3);
    chk("t1_acc0_we", {31'd0, tr_we[1]}, 1);
    chk("t1_acc0_addr", {28'd0, tr_addr[1]}, 4);
    chk("t1_acc0_din", {28'd0, tr_din[1]}, 4'hA);
    chk("t1_acc1_we", {31'd0, tr_we[2]}, 1);
    chk("t1_acc1_addr", {28'd0, tr_addr[2]}, 5);
    chk("t1_acc1_din", {28'd0, tr_din[2]}, 4'h3);
    chk("t1_r4", {28'd0, rf[4]}, 4'hA);
    chk("t1_r5", {28'd0, rf[5]}, 4'h3);

    // test 2: reads back
    issue(1, RD8, 4'h4, 8'h00, 8'hA3, 3);
    chk("t2_rd8_we", {31'd0, tr_we[1]}, 0);
    issue(0, RD4, 4'h5, 8'h00, 8'h03, 2);
    issue(1, WR4, 4'h9, 8'hF6, 8'h00, 2);
    chk("t2_wr4_addr", {28'd0, tr_addr[1]}, 9);
    chk("t2_r9", {28'd0, rf[9]}, 4'h6);

    // test 5: stall in DONE
    c_rsp_ready = 0;
    issue(0, RD4, 4'h4, 8'h00, 8'h0A, 2);
    d_req_valid = 1; d_req_op = RD4; d_req_addr = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid", {31'd0, c_rsp_valid}, 1);
      chk("t5_rdata", {24'd0, c_rsp_rdata}, 8'h0A);
      chk("t5_we", {31'd0, reg_we}, 0);
      chk("t5_dready", {31'd0, d_req_ready}, 0);
    end
    @(posedge clk);
    #1;
    d_req_valid = 0;
    c_rsp_ready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("t5_sb_empty", sb.size(), 0);

    // test 3: round-robin from reset
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    c_req_valid = 1; c_req_op = RD4; c_req_addr = 4'h4;
    d_req_valid = 1; d_req_op = RD4; d_req_addr = 4'h5;
    g = 0;
    n = 0;
    while (g < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (c_req_ready && d_req_ready) begin
        checks++;
        errors++;
        $display("FAIL t3_both_ready: c=1 d=1");
      end
      if (c_req_ready) begin
        ord[g] = 0; g++;
        sb.push_back({1'b0, 8'h0A});
      end else if (d_req_ready) begin
        ord[g] = 1; g++;
        sb.push_back({1'b1, 8'h03});
      end
    end
    @(posedge clk);
    #1;
    c_req_valid = 0;
    d_req_valid = 0;
    chk("t3_grants", g, 4);
    chk("t3_g0", {31'd0, ord[0]}, 0);
    chk("t3_g1", {31'd0, ord[1]}, 1);
    chk("t3_g2", {31'd0, ord[2]}, 0);
    chk("t3_g3", {31'd0, ord[3]}, 1);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("t3_drain", sb.size(), 0);

    // test 6: reset during ACC1 of WR8
    c_req_valid = 1; c_req_op = WR8;
    c_req_addr = 4'h2; c_req_wdata = 8'h7E;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!c_req_ready && n < 50);
    chk("t6_accept", {31'd0, c_req_ready}, 1);
    @(posedge clk);
    #1 c_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_acc1_addr", {28'd0, reg_addr}, 3);
    rst = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_we", {31'd0, reg_we}, 0);
    chk("t6_addr", {28'd0, reg_addr}, 0);
    chk("t6_din", {28'd0, reg_din}, 0);
    chk("t6_rsp", {31'd0, c_rsp_valid}, 0);
    chk("t6_r2", {28'd0, rf[2]}, 4'h7);
    chk("t6_r3", {28'd0, rf[3]}, 4'h0);
    @(posedge clk);
    #1 rst = 0;

    // test 4: fixed priority instance
    c2_req_valid = 1;
    d2_req_valid = 1;
    cg = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("t4_d_not_ready", {31'd0, d2_req_ready}, 0);
      if (c2_req_ready) cg++;
    end
    chk("t4_core_grants", {31'd0, cg >= 6}, 1);
    @(posedge clk);
    #1 c2_req_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d2_req_ready && n < 20);
    chk("t4_d_granted", {31'd0, d2_req_ready}, 1);
    @(posedge clk);
    #1 d2_req_valid = 0;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
